single_port_ram_sync: RTL and testbench



---
 rtl/single_port_ram_sync.sv | 45 ++++
 tb/tb_single_port_ram_sync.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/single_port_ram_sync.sv
// Synchronous single-port RAM with a registered, write-first read port.
// A synchronous reset clears every stored word and the output register.
module single_port_ram_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  // Write-first: a write echoes its own data instead of the old contents.
  always_comb begin
    data_out_d = mem_q[addr];
    if (we) begin
      data_out_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_out_q <= '0;
    end else begin
      if (we) begin
        mem_q[addr] <= data_in;
      end
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_single_port_ram_sync.sv
// Self-checking bench for single_port_ram_sync: expected read data is queued
// when each operation is driven and compared after the clock edge.
module tb_single_port_ram_sync;

  logic       clk;
  logic       rst;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic       we;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] model [8];

  single_port_ram_sync #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .data_in (data_in),
    .we      (we),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  // Drive one operation, let one rising edge take it, sample shortly after.
  task automatic op(input logic r, input logic w, input logic [2:0] a,
                    input logic [7:0] d, output logic [7:0] obs);
    @(negedge clk);
    rst = r;
    we = w;
    addr = a;
    data_in = d;
    @(posedge clk);
    #1;
    obs = data_out;
    if (r) begin
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
    end else if (w) begin
      model[a] = d;
    end
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    logic [7:0] exp;
    exp_q.push_back(8'h00);
    op(1'b1, 1'b0, 3'd0, 8'h00, obs);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_out: got %h required %h", obs, exp);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h00);
      op(1'b0, 1'b0, 3'(i), 8'h00, obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_read addr %0d: got %h required %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_write_read();
    logic       w_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] a_tab [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
    logic [7:0] d_tab [4] = '{8'hA1, 8'hB2, 8'h00, 8'h00};
    logic [7:0] e_tab [4] = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};
    logic [7:0] obs;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(e_tab[i]);
      op(1'b0, w_tab[i], a_tab[i], d_tab[i], obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL write_read step %0d: got %h required %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       w_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0] a_tab [6] = '{3'd2, 3'd2, 3'd0, 3'd1, 3'd1, 3'd3};
    logic [7:0] d_tab [6] = '{8'hC3, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00};
    logic [7:0] e_tab [6] = '{8'hC3, 8'hC3, 8'hA1, 8'h5A, 8'h5A, 8'h00};
    logic [7:0] obs;
    logic [7:0] exp;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(e_tab[i]);
      op(1'b0, w_tab[i], a_tab[i], d_tab[i], obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %h required %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_priority();
    logic       r_tab [3] = '{1'b1, 1'b0, 1'b0};
    logic       w_tab [3] = '{1'b1, 1'b0, 1'b0};
    logic [2:0] a_tab [3] = '{3'd4, 3'd4, 3'd0};
    logic [7:0] d_tab [3] = '{8'hFF, 8'h00, 8'h00};
    logic [7:0] obs;
    logic [7:0] exp;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h00);
      op(r_tab[i], w_tab[i], a_tab[i], d_tab[i], obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_priority step %0d: got %h required %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_fill_reverse();
    logic [7:0] obs;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      op(1'b0, 1'b1, 3'(i), 8'h10 + 8'(i), obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL fill_echo addr %0d: got %h required %h", i, obs, exp);
      end
    end
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(8'h10 + 8'(i));
      op(1'b0, 1'b0, 3'(i), 8'h00, obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reverse_read addr %0d: got %h required %h", i, obs, exp);
      end
      // Disturb every input mid-cycle; the registered output must not move.
      #1;
      addr = ~addr;
      we = 1'b0;
      data_in = 8'hEE;
      #1;
      checks++;
      if (data_out !== exp) begin
        errors++;
        $display("FAIL hold_between_edges addr %0d: got %h required %h", i, data_out, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] obs;
    logic [7:0] exp;
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(w ? d : model[a]);
      op(1'b0, w, a, d, obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random op %0d (we=%0b addr=%0d): got %h required %h", i, w, a, obs, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    we = 1'b0;
    addr = '0;
    data_in = '0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_priority();
    test_fill_reverse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
